// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline.
// Write-back source, destination select and load-type codes.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_LINK = 2'd2
  } dst_sel_e;

  typedef enum logic [2:0] {
    LD_WORD = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4
  } ld_type_e;

endpackage

// File: rtl/load_extend.sv
// Load lane extraction with sign/zero extension.
// Ports: rdata (raw word), off (byte offset), ld_type -> ext.
module load_extend
  import mips_pkg::*;
#(
  parameter  int DW = 32,
  localparam int BO = $clog2(DW / 8)
) (
  input  logic [DW-1:0] rdata,
  input  logic [BO-1:0] off,
  input  logic [2:0]    ld_type,
  output logic [DW-1:0] ext
);

  logic [BO+2:0] w_bsh;
  logic [BO+2:0] w_hsh;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // Halfword lane ignores off[0]; misaligned halves are not trapped.
  assign w_bsh  = {off, 3'b000};
  assign w_hsh  = {off[BO-1:1], 4'b0000};
  assign w_byte = rdata[w_bsh +: 8];
  assign w_half = rdata[w_hsh +: 16];

  always_comb begin
    ext = rdata;
    case (ld_type)
      LD_B:  ext = {{(DW-8){w_byte[7]}}, w_byte};
      LD_BU: ext = {{(DW-8){1'b0}}, w_byte};
      LD_H:  ext = {{(DW-16){w_half[15]}}, w_half};
      LD_HU: ext = {{(DW-16){1'b0}}, w_half};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register, write-back select and retire counter.
// In: clk, reset(n), stall, flush, m_*. Out: wb_valid/we/a3/wd3, retire_cnt.
module wb_stage_reg
  import mips_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31,
  parameter int CNTW     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            m_valid,
  input  logic            m_reg_we,
  input  logic [1:0]      m_wb_sel,
  input  logic [1:0]      m_dst_sel,
  input  logic [2:0]      m_ld_type,
  input  logic [AW-1:0]   m_rt,
  input  logic [AW-1:0]   m_rd,
  input  logic [DW-1:0]   m_alu_result,
  input  logic [DW-1:0]   m_dm_rdata,
  input  logic [DW-1:0]   m_pc,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [AW-1:0]   wb_a3,
  output logic [DW-1:0]   wb_wd3,
  output logic [CNTW-1:0] retire_cnt
);

  localparam int BO = $clog2(DW / 8);

  logic [DW-1:0]   w_ext;
  logic [DW-1:0]   w_link;
  logic [DW-1:0]   w_wd;
  logic [AW-1:0]   w_a3;
  logic            w_we;

  logic            r_valid;
  logic            r_we;
  logic [AW-1:0]   r_a3;
  logic [DW-1:0]   r_wd;
  logic [CNTW-1:0] r_cnt;

  load_extend #(.DW(DW)) u_ext (
    .rdata   (m_dm_rdata),
    .off     (m_alu_result[BO-1:0]),
    .ld_type (m_ld_type),
    .ext     (w_ext)
  );

  assign w_link = m_pc + DW'(8);

  always_comb begin
    w_a3 = m_rt;
    case (m_dst_sel)
      DST_RD:   w_a3 = m_rd;
      DST_LINK: w_a3 = AW'(LINK_REG);
      default:  w_a3 = m_rt;
    endcase
  end

  always_comb begin
    w_wd = m_alu_result;
    case (m_wb_sel)
      WB_MEM:  w_wd = w_ext;
      WB_LINK: w_wd = w_link;
      default: w_wd = m_alu_result;
    endcase
  end

  // Register 0 is hardwired; never request a write to it.
  assign w_we = m_valid & m_reg_we & (w_a3 != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_a3    <= '0;
      r_wd    <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_a3    <= '0;
      r_wd    <= '0;
    end else if (!stall) begin
      r_valid <= m_valid;
      r_we    <= w_we;
      r_a3    <= w_a3;
      r_wd    <= w_wd;
      if (m_valid) r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign wb_valid   = r_valid;
  assign wb_we      = r_we;
  assign wb_a3      = r_a3;
  assign wb_wd3     = r_wd;
  assign retire_cnt = r_cnt;

endmodule
